ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
Host-side PS/2 keyboard receiver: the receiving end of the PS/2 device-to-host serial frames that our io block emits on ps2_kbd_clk/ps2_kbd_data. It oversamples the PS/2 lines on clk_sys, deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop) and reports raw bytes. It also decodes set-2 prefixes (E0 = extended, F0 = break) into single key events for the core's keyboard matrix logic.

Parameters:
FILT_LEN, 8, consecutive equal clk_sys samples required before a filtered PS/2 line changes level (range 2..255)
TIMEOUT, 50000, clk_sys cycles without a falling edge while mid-frame before the frame is aborted (16-bit counter)

Ports:
clk_sys  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-high reset
ps2_clk  in  1  PS/2 clock line, asynchronous
ps2_data  in  1  PS/2 data line, asynchronous
rx_byte  out  8  last correctly received byte
rx_valid  out  1  one-cycle strobe: rx_byte updated
parity_err  out  1  one-cycle strobe: parity check failed
frame_err  out  1  one-cycle strobe: bad stop bit or timeout
busy  out  1  frame in progress (state != IDLE)
key_code  out  8  scancode of last key event, prefixes stripped
key_extended  out  1  event was preceded by E0
key_pressed  out  1  1 = make, 0 = break (preceded by F0)
key_strobe  out  1  one-cycle strobe: key_* updated

Behaviour:
- Reset: all outputs 0; synchronizer and filter registers set to 1 (idle bus); FSM set to IDLE; prefix flags cleared.
- Input conditioning: 2-flop synchronizer on each line, followed by a FILT_LEN filter. A filtered falling edge on clk produces one internal pulse fe; at fe, data is taken from the filtered data line.
- Frame FSM, which advances only on fe:
  - IDLE: data==0 -> DATA with bit_cnt=0; data==1 -> stay in IDLE (stray edge ignored, no error).
  - DATA: shift in LSB-first; after the 8th bit -> PARITY.
  - PARITY: latch the parity bit -> STOP.
  - STOP: always -> IDLE, with one of three outcomes:
    - stop==0: frame_err.
    - stop==1 and the XOR of 8 data bits and parity == 0: parity_err.
    - otherwise: rx_byte updated, rx_valid.
- Strobe timing: each strobe is high for exactly one cycle, the cycle after the STOP-state fe. Strobes are mutually exclusive. rx_byte holds its value until the next good frame.
- Timeout: counter cleared on every fe and held at 0 in IDLE. If it reaches TIMEOUT-1 outside IDLE: FSM -> IDLE and frame_err pulses next cycle. A fe arriving in the same cycle as the timeout is discarded.
- busy = (state != IDLE), registered.
- Decoder, acting on rx_valid:
  - 8'hE0 sets ext_pend.
  - 8'hF0 sets rel_pend.
  - 8'hAA, 8'hFA, 8'hEE, 8'hFE (BAT/ack/echo/resend) produce no key event and leave pends unchanged.
  - Any other byte: next cycle key_code=byte, key_extended=ext_pend, key_pressed=~rel_pend, key_strobe=1; both pends cleared.
  - parity_err or frame_err clears both pends.
  - Total latency from the STOP-state fe to key_strobe is 2 cycles.
- Reset mid-frame: frame is discarded with no strobes. A low ps2_clk after reset release may create one fe, which is absorbed by the start-bit check or by the timeout.

Decomposition:
- Shared package ps2_pkg holds:
  - state enum {IDLE, DATA, PARITY, STOP};
  - byte constants PS2_EXT=8'hE0, PS2_REL=8'hF0, PS2_BAT=8'hAA, PS2_ACK=8'hFA, PS2_ECHO=8'hEE, PS2_RESEND=8'hFE.
- One sub-module, ps2_rx_frame: synchronizer, filter, frame FSM and timeout. It drives rx_byte, rx_valid, parity_err, frame_err and busy.
- The top level, ps2_kbd_rx, instantiates ps2_rx_frame and adds the prefix decoder.

Test Plan:
1. Frame 0x1C, parity 0, stop 1, bit period 200 cycles -> rx_valid once with rx_byte=8'h1C; 1 cycle later key_strobe with key_code=8'h1C, key_pressed=1, key_extended=0.
2. Bytes F0,1C -> two rx_valid, a single key_strobe with key_code=8'h1C, key_pressed=0. Then E0,F0,74 -> key_code=8'h74, key_extended=1, key_pressed=0.
3. Byte E0, then 0x1C with parity 1 (parity_err pulse, no rx_valid), then 0x74 -> key_code=8'h74, key_extended=0. Byte FA alone -> rx_valid and no key_strobe.
4. Frame 0x1C with stop 0 -> frame_err once, no rx_valid, busy returns to 0. Clock halted after 4 data bits -> frame_err exactly TIMEOUT cycles after the last fe (+1 cycle), then a good 0x29 frame is received.
5. 3-cycle low glitch on ps2_clk with FILT_LEN=8 -> no state change, busy stays 0. 8-cycle low pulse with data=1 -> ignored in IDLE.
6. reset pulsed after the 5th data bit -> all outputs 0 with no strobe; the following 0x5A frame produces key_code=8'h5A, key_pressed=1.

Source files
------------

// File: rtl/ps2_kbd_rx_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared types and constants for the PS/2 keyboard receiver.
//   state_t       : frame deserialiser states
//   PS2_*         : set-2 prefix and controller-response byte values
//   is_ctrl_byte  : true for bytes that never form a key event
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic [7:0] PS2_EXT    = 8'hE0;  // extended-key prefix
  localparam logic [7:0] PS2_REL    = 8'hF0;  // break (key release) prefix
  localparam logic [7:0] PS2_BAT    = 8'hAA;  // self-test passed
  localparam logic [7:0] PS2_ACK    = 8'hFA;  // command acknowledge
  localparam logic [7:0] PS2_ECHO   = 8'hEE;  // echo response
  localparam logic [7:0] PS2_RESEND = 8'hFE;  // resend request

  // Keyboard responses that carry no key information.
  function automatic logic is_ctrl_byte(input logic [7:0] b);
    return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_ECHO) || (b == PS2_RESEND);
  endfunction

endpackage

// File: rtl/ps2_kbd_rx_if.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx_if
// Result bundle of the PS/2 keyboard receiver.
//   rx_byte/rx_valid          : raw byte stream
//   parity_err/frame_err      : reception error strobes
//   busy                      : frame in progress
//   key_code/key_extended/
//   key_pressed/key_strobe    : decoded key events
// master = receiver (drives), slave = consumer (reads).
// ---------------------------------------------------------------------------
interface ps2_kbd_rx_if;

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_pressed;
  logic       key_strobe;

  modport master (
    output rx_byte, rx_valid, parity_err, frame_err, busy,
           key_code, key_extended, key_pressed, key_strobe
  );

  modport slave (
    input  rx_byte, rx_valid, parity_err, frame_err, busy,
           key_code, key_extended, key_pressed, key_strobe
  );

endinterface

// File: rtl/ps2_rx_frame.sv
// ---------------------------------------------------------------------------
// ps2_rx_frame
// Conditions the asynchronous PS/2 lines and deframes 11-bit device-to-host
// frames (start, 8 data LSB-first, odd parity, stop).
// Ports:
//   clk_sys, reset        : system clock, async active-high reset
//   ps2_clk, ps2_data     : raw PS/2 lines
//   rx_byte               : last good byte (held until the next good frame)
//   rx_valid              : 1-cycle strobe, rx_byte updated
//   parity_err            : 1-cycle strobe, parity check failed
//   frame_err             : 1-cycle strobe, stop bit low or timeout
//   busy                  : frame in progress
// ---------------------------------------------------------------------------
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 50000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [7:0]  FILT_MAX = 8'(FILT_LEN - 1);
  localparam logic [15:0] TO_MAX   = 16'(TIMEOUT - 1);

  // Index 0 = clock line, index 1 = data line.
  logic [1:0]      sync_a;
  logic [1:0]      sync_b;
  logic [1:0]      filt;
  logic [1:0][7:0] filt_cnt;
  logic            filt_clk_d;
  logic            fe;
  logic            data_bit;

  // Lines idle high, so the conditioning chain resets to 1 to avoid a
  // phantom falling edge right after reset.
  // NOTE: sequential state is assigned with <= only, so every register samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync_a     <= 2'b11;
      sync_b     <= 2'b11;
      filt       <= 2'b11;
      filt_cnt   <= '0;
      filt_clk_d <= 1'b1;
    end else begin
      sync_a     <= {ps2_data, ps2_clk};
      sync_b     <= sync_a;
      filt_clk_d <= filt[0];
      // A line changes level only after FILT_LEN consecutive opposite samples.
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == filt[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == FILT_MAX) begin
          filt[i]     <= sync_b[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 8'd1;
        end
      end
    end
  end

  assign fe       = filt_clk_d & ~filt[0];
  assign data_bit = filt[1];

  // Frame FSM and datapath.
  state_t      state, state_next;
  logic [7:0]  shift, shift_next;
  logic [2:0]  bit_cnt, bit_cnt_next;
  logic        par_bit, par_bit_next;
  logic [7:0]  byte_next;
  logic        valid_next, perr_next, ferr_next;
  logic [15:0] to_cnt;
  logic        timeout;

  assign timeout = (state != IDLE) && (to_cnt == TO_MAX);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      par_bit    <= 1'b0;
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      shift      <= shift_next;
      bit_cnt    <= bit_cnt_next;
      par_bit    <= par_bit_next;
      rx_byte    <= byte_next;
      rx_valid   <= valid_next;
      parity_err <= perr_next;
      frame_err  <= ferr_next;
      busy       <= (state_next != IDLE);
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_cnt_next = bit_cnt;
    par_bit_next = par_bit;
    byte_next    = rx_byte;
    valid_next   = 1'b0;
    perr_next    = 1'b0;
    ferr_next    = 1'b0;

    if (timeout) begin
      // A falling edge coinciding with the timeout is dropped.
      state_next = IDLE;
      ferr_next  = 1'b1;
    end else if (fe) begin
      unique case (state)
        IDLE: begin
          // A high data line here is a stray edge, not a start bit.
          if (!data_bit) begin
            state_next   = DATA;
            bit_cnt_next = '0;
          end
        end
        DATA: begin
          shift_next   = {data_bit, shift[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = PARITY;
        end
        PARITY: begin
          par_bit_next = data_bit;
          state_next   = STOP;
        end
        STOP: begin
          state_next = IDLE;
          if (!data_bit) begin
            ferr_next = 1'b1;
          end else if ((^shift ^ par_bit) == 1'b0) begin
            perr_next = 1'b1;
          end else begin
            byte_next  = shift;
            valid_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Watchdog for a clock that stops mid-frame; idles at 0 between frames.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (state == IDLE || fe) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx
// Host-side PS/2 keyboard receiver: raw byte reception plus set-2 prefix
// decoding (E0 = extended, F0 = break) into single key events.
// Ports:
//   clk_sys, reset        : system clock, async active-high reset
//   ps2_clk, ps2_data     : raw PS/2 lines
//   bus (master)          : rx_byte/rx_valid/parity_err/frame_err/busy and
//                           key_code/key_extended/key_pressed/key_strobe
// ---------------------------------------------------------------------------
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int FILT_LEN = 8,
  parameter int TIMEOUT  = 50000
) (
  input  logic           clk_sys,
  input  logic           reset,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  ps2_kbd_rx_if.master   bus
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  ps2_rx_frame #(
    .FILT_LEN (FILT_LEN),
    .TIMEOUT  (TIMEOUT)
  ) u_frame (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // Prefix decoder: prefixes accumulate in the pend flags until a real
  // scancode arrives; a reception error means the sequence is lost.
  logic       ext_pend;
  logic       rel_pend;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_pressed;
  logic       key_strobe;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ext_pend     <= 1'b0;
      rel_pend     <= 1'b0;
      key_code     <= '0;
      key_extended <= 1'b0;
      key_pressed  <= 1'b0;
      key_strobe   <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      if (rx_valid) begin
        if (rx_byte == PS2_EXT) begin
          ext_pend <= 1'b1;
        end else if (rx_byte == PS2_REL) begin
          rel_pend <= 1'b1;
        end else if (!is_ctrl_byte(rx_byte)) begin
          key_code     <= rx_byte;
          key_extended <= ext_pend;
          key_pressed  <= ~rel_pend;
          key_strobe   <= 1'b1;
          ext_pend     <= 1'b0;
          rel_pend     <= 1'b0;
        end
      end else if (parity_err || frame_err) begin
        ext_pend <= 1'b0;
        rel_pend <= 1'b0;
      end
    end
  end

  assign bus.rx_byte      = rx_byte;
  assign bus.rx_valid     = rx_valid;
  assign bus.parity_err   = parity_err;
  assign bus.frame_err    = frame_err;
  assign bus.busy         = busy;
  assign bus.key_code     = key_code;
  assign bus.key_extended = key_extended;
  assign bus.key_pressed  = key_pressed;
  assign bus.key_strobe   = key_strobe;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_kbd_rx
// Directed bench for ps2_kbd_rx: drives PS/2 frames bit by bit, tallies the
// strobes seen on the result bus and compares against hand-derived values.
// ---------------------------------------------------------------------------
module tb_ps2_kbd_rx;

  localparam int FILT_LEN = 8;
  localparam int TIMEOUT  = 1000;
  localparam int HALF     = 100;  // half of a 200-cycle PS/2 bit period

  logic clk_sys  = 1'b0;
  logic reset    = 1'b1;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  always #5 clk_sys = ~clk_sys;

  ps2_kbd_rx_if bus ();

  ps2_kbd_rx #(
    .FILT_LEN (FILT_LEN),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Strobe monitor, sampled on the falling system-clock edge.
  int         cyc        = 0;
  int         n_valid    = 0;
  int         n_perr     = 0;
  int         n_ferr     = 0;
  int         n_key      = 0;
  int         n_busy     = 0;
  int         n_overlap  = 0;
  int         valid_cyc  = 0;
  int         key_cyc    = 0;
  int         ferr_cyc   = 0;
  logic [7:0] last_byte  = '0;
  logic [7:0] last_code  = '0;
  logic       last_ext   = 1'b0;
  logic       last_press = 1'b0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (bus.rx_valid) begin
      n_valid   <= n_valid + 1;
      valid_cyc <= cyc;
      last_byte <= bus.rx_byte;
    end
    if (bus.parity_err) n_perr <= n_perr + 1;
    if (bus.frame_err) begin
      n_ferr   <= n_ferr + 1;
      ferr_cyc <= cyc;
    end
    if (bus.key_strobe) begin
      n_key      <= n_key + 1;
      key_cyc    <= cyc;
      last_code  <= bus.key_code;
      last_ext   <= bus.key_extended;
      last_press <= bus.key_pressed;
    end
    if (bus.busy) n_busy <= n_busy + 1;
    if ((32'(bus.rx_valid) + 32'(bus.parity_err) + 32'(bus.frame_err)) > 1)
      n_overlap <= n_overlap + 1;
  end

  int last_fall = 0;

  // One PS/2 bit: data changes while the clock is high, host samples at fall.
  task automatic ps2_bit(input logic v);
    ps2_data = v;
    repeat (HALF) @(negedge clk_sys);
    ps2_clk   = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(negedge clk_sys);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~(^b) ^ bad_par);
    ps2_bit(stop);
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk_sys);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_byte"},  32'(bus.rx_byte),  32'h0);
    check({tag, "_strobes"},  32'({bus.rx_valid, bus.parity_err, bus.frame_err, bus.key_strobe}), 32'h0);
    check({tag, "_busy"},     32'(bus.busy),     32'h0);
    check({tag, "_key"},      32'({bus.key_code, bus.key_extended, bus.key_pressed}), 32'h0);
  endtask

  int v0, p0, f0, k0, b0, w, lat;
  logic [7:0] part;

  initial begin
    repeat (5) @(negedge clk_sys);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (20) @(negedge clk_sys);

    // 1: single make code, strobe latency
    v0 = n_valid; k0 = n_key;
    send_byte(8'h1C);
    check("t1_valid_cnt", 32'(n_valid - v0), 32'd1);
    check("t1_rx_byte",   32'(last_byte), 32'h1C);
    check("t1_key_cnt",   32'(n_key - k0), 32'd1);
    check("t1_key",       32'({last_code, last_ext, last_press}), {23'd0, 8'h1C, 1'b0, 1'b1});
    check("t1_key_lat",   32'(key_cyc - valid_cyc), 32'd1);
    check("t1_busy_idle", 32'(bus.busy), 32'd0);

    // 2: break, then extended break
    v0 = n_valid; k0 = n_key;
    send_byte(8'hF0);
    send_byte(8'h1C);
    check("t2_valid_cnt", 32'(n_valid - v0), 32'd2);
    check("t2_key_cnt",   32'(n_key - k0), 32'd1);
    check("t2_key",       32'({last_code, last_ext, last_press}), {23'd0, 8'h1C, 1'b0, 1'b0});
    k0 = n_key;
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h74);
    check("t2_ext_cnt",   32'(n_key - k0), 32'd1);
    check("t2_ext_key",   32'({last_code, last_ext, last_press}), {23'd0, 8'h74, 1'b1, 1'b0});

    // 3: parity error drops the pending prefix; ack byte is not a key
    v0 = n_valid; p0 = n_perr; k0 = n_key;
    send_byte(8'hE0);
    send_frame(8'h1C, 1'b1, 1'b1);
    check("t3_perr_cnt",  32'(n_perr - p0), 32'd1);
    check("t3_valid_cnt", 32'(n_valid - v0), 32'd1);
    send_byte(8'h74);
    check("t3_key_cnt",   32'(n_key - k0), 32'd1);
    check("t3_key",       32'({last_code, last_ext, last_press}), {23'd0, 8'h74, 1'b0, 1'b1});
    v0 = n_valid; k0 = n_key;
    send_byte(8'hFA);
    check("t3_ack_valid", 32'(n_valid - v0), 32'd1);
    check("t3_ack_byte",  32'(last_byte), 32'hFA);
    check("t3_ack_nokey", 32'(n_key - k0), 32'd0);

    // 4a: bad stop bit
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h1C, 1'b0, 1'b0);
    check("t4_stop_ferr",  32'(n_ferr - f0), 32'd1);
    check("t4_stop_noval", 32'(n_valid - v0), 32'd0);
    check("t4_stop_busy",  32'(bus.busy), 32'd0);

    // 4b: clock stops after 4 data bits
    f0 = n_ferr; part = 8'hA5;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(part[i]);
    ps2_data = 1'b1;
    check("t4_to_busy", 32'(bus.busy), 32'd1);
    w = 0;
    while (n_ferr == f0 && w < TIMEOUT + 500) begin
      @(negedge clk_sys);
      w++;
    end
    check("t4_to_fired", 32'(n_ferr - f0), 32'd1);
    lat = ferr_cyc - last_fall;
    check("t4_to_latency_ok",
          32'((lat >= TIMEOUT + FILT_LEN) && (lat <= TIMEOUT + FILT_LEN + 5)), 32'd1);
    repeat (10) @(negedge clk_sys);
    check("t4_to_busy_clr", 32'(bus.busy), 32'd0);
    v0 = n_valid; k0 = n_key;
    send_byte(8'h29);
    check("t4_after_valid", 32'(n_valid - v0), 32'd1);
    check("t4_after_byte",  32'(last_byte), 32'h29);
    check("t4_after_key",   32'({last_code, last_ext, last_press}), {23'd0, 8'h29, 1'b0, 1'b1});

    // 5: glitch rejection and stray edge in IDLE
    v0 = n_valid; p0 = n_perr; f0 = n_ferr; b0 = n_busy;
    ps2_data = 1'b0;
    repeat (10) @(negedge clk_sys);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (50) @(negedge clk_sys);
    check("t5_glitch_busy", 32'(n_busy - b0), 32'd0);
    ps2_data = 1'b1;
    repeat (10) @(negedge clk_sys);
    ps2_clk = 1'b0;
    repeat (FILT_LEN) @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (50) @(negedge clk_sys);
    check("t5_stray_busy", 32'(n_busy - b0), 32'd0);
    check("t5_no_events",  32'((n_valid - v0) + (n_perr - p0) + (n_ferr - f0)), 32'd0);

    // 6: reset mid-frame
    v0 = n_valid; p0 = n_perr; f0 = n_ferr; k0 = n_key;
    part = 8'h3F;
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(part[i]);
    ps2_data = 1'b1;
    check("t6_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    check_all_zero("t6_in_reset");
    reset = 1'b0;
    repeat (20) @(negedge clk_sys);
    check_all_zero("t6_after_reset");
    check("t6_no_strobes", 32'((n_valid - v0) + (n_perr - p0) + (n_ferr - f0) + (n_key - k0)), 32'd0);
    send_byte(8'h5A);
    check("t6_valid_cnt", 32'(n_valid - v0), 32'd1);
    check("t6_key",       32'({last_code, last_ext, last_press}), {23'd0, 8'h5A, 1'b0, 1'b1});

    check("strobes_exclusive", 32'(n_overlap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
